// File: rtl/fp16_pkg.sv
// Shared FP16 constants, slot-state type and the operand-slot slicing helper
// used by the shared-adder arbiter and its fpadder.
package fp16_pkg;

    localparam int FP16_W = 16;
    localparam int EXP_W  = 5;
    localparam int MAN_W  = 10;

    localparam logic [FP16_W-1:0] FP16_ONE   = 16'h3C00;
    localparam logic [FP16_W-1:0] FP16_TWO   = 16'h4000;
    localparam logic [FP16_W-1:0] FP16_THREE = 16'h4200;

    // Packed operand buses are widened to the largest supported requester count
    localparam int MAX_SLOTS  = 8;
    localparam int SLOT_VEC_W = FP16_W * MAX_SLOTS;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    function automatic logic [FP16_W-1:0] op_slot(input logic [SLOT_VEC_W-1:0] vec,
                                                  input int idx);
        return vec[FP16_W*idx +: FP16_W];
    endfunction

endpackage

// File: rtl/fp16_add_arbiter_rr.sv
// Combinational round-robin arbiter; the pointer holds the last winner and the
// search starts one past it.
module rr_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic            advance,
    input  logic [ID_W-1:0] winner_in,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] gnt_id
);

    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] idx;
    logic            found;

    always_ff @(posedge clk) begin
        if (rst)          ptr <= ID_W'(N - 1);
        else if (advance) ptr <= winner_in;
    end

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 1; k <= N; k++) begin
            idx = ID_W'((int'(ptr) + k) % N);
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = idx;
            end
        end
    end

endmodule

// File: rtl/fpadder.sv
// Registered FP16 adder: normal numbers only, zero exponent treated as zero,
// result truncated toward zero, underflow flushed to zero.
module fpadder
    import fp16_pkg::*;
(
    input  logic              CLK,
    input  logic              RESETn,
    input  logic [FP16_W-1:0] A,
    input  logic [FP16_W-1:0] B,
    output logic [FP16_W-1:0] SUM
);

    function automatic logic [FP16_W-1:0] fp_add(input logic [FP16_W-1:0] x,
                                                 input logic [FP16_W-1:0] y);
        logic [FP16_W-1:0] a, b, r;
        logic [EXP_W-1:0]  ea, eb, d;
        logic [MAN_W+3:0]  ma, mb, mb_al;
        logic [MAN_W+4:0]  s, sh;
        logic              sticky;
        int                lead, e_i;
        if (x[14:0] >= y[14:0]) begin a = x; b = y; end
        else                    begin a = y; b = x; end
        ea = a[14:10];
        eb = b[14:10];
        ma = (ea != '0) ? {1'b1, a[9:0], 3'b000} : '0;
        mb = (eb != '0) ? {1'b1, b[9:0], 3'b000} : '0;
        d      = ea - eb;
        mb_al  = mb >> d;
        sticky = |(mb & ~(14'h3FFF << d));
        // Borrowing the sticky bit keeps subtraction truncating toward zero
        if (a[15] == b[15]) s = {1'b0, ma} + {1'b0, mb_al};
        else                s = {1'b0, ma} - {1'b0, mb_al} - {14'b0, sticky};
        lead = -1;
        for (int i = 0; i < 15; i++) if (s[i]) lead = i;
        r  = '0;
        sh = '0;
        if (lead >= 0) begin
            e_i = int'(ea) + lead - 13;
            sh  = s << (14 - lead);
            if (e_i > 0) r = {a[15], 5'(e_i), 10'(sh >> 4)};
        end
        return r;
    endfunction

    always_ff @(posedge CLK) begin
        if (!RESETn) SUM <= '0;
        else         SUM <= fp_add(A, B);
    end

endmodule

// File: rtl/fp16_add_arbiter.sv
// Shares one registered fpadder among N_REQ requesters with a one-entry tagged result slot.
// FPADD_ARB_STATS_EN adds saturating per-requester grant counters on stat_cnt.
module fp16_add_arbiter
    import fp16_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [FP16_W*N_REQ-1:0] req_a,
    input  logic [FP16_W*N_REQ-1:0] req_b,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [FP16_W-1:0]       resp_sum,
    output logic [ID_W-1:0]         resp_id,
    output logic [16*N_REQ-1:0]     stat_cnt
);

    // state      | meaning
    // SLOT_EMPTY | no result held; any valid request may issue
    // SLOT_FULL  | result held; issue only when the consumer takes it this cycle
    slot_state_t state_q, state_d;

    logic              can_issue;
    logic              issue;
    logic [N_REQ-1:0]  gnt;
    logic [ID_W-1:0]   gnt_id;
    logic [FP16_W-1:0] held_a, held_b, add_a, add_b;

    assign can_issue = (state_q == SLOT_EMPTY) || resp_ready;

    rr_arbiter #(.N(N_REQ), .ID_W(ID_W)) u_rr (
        .clk       (CLK),
        .rst       (RESET),
        .req       (req_valid & {N_REQ{can_issue}}),
        .advance   (issue),
        .winner_in (gnt_id),
        .gnt       (gnt),
        .gnt_id    (gnt_id)
    );

    assign issue     = |gnt;
    assign req_ready = gnt;

    // Feeding the held operands when idle keeps resp_sum stable through stalls
    assign add_a = issue ? op_slot(SLOT_VEC_W'(req_a), int'(gnt_id)) : held_a;
    assign add_b = issue ? op_slot(SLOT_VEC_W'(req_b), int'(gnt_id)) : held_b;

    fpadder u_add (
        .CLK    (CLK),
        .RESETn (~RESET),
        .A      (add_a),
        .B      (add_b),
        .SUM    (resp_sum)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= SLOT_EMPTY;
            resp_id <= '0;
            held_a  <= '0;
            held_b  <= '0;
        end else begin
            state_q <= state_d;
            if (issue) begin
                resp_id <= gnt_id;
                held_a  <= add_a;
                held_b  <= add_b;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SLOT_EMPTY: if (issue) state_d = SLOT_FULL;
            SLOT_FULL:  if (resp_ready && !issue) state_d = SLOT_EMPTY;
            default:    state_d = SLOT_EMPTY;
        endcase
    end

    assign resp_valid = (state_q == SLOT_FULL);

`ifdef FPADD_ARB_STATS_EN
    logic [15:0] cnt_q [N_REQ];

    always_ff @(posedge CLK) begin
        for (int i = 0; i < N_REQ; i++) begin
            if (RESET)                               cnt_q[i] <= '0;
            else if (gnt[i] && cnt_q[i] != 16'hFFFF) cnt_q[i] <= cnt_q[i] + 16'd1;
        end
    end

    for (genvar g = 0; g < N_REQ; g++) begin : g_stat
        assign stat_cnt[16*g +: 16] = cnt_q[g];
    end
`else
    assign stat_cnt = '0;
`endif

endmodule

// File: tb/tb_fp16_add_arbiter.sv
// Bench for fp16_add_arbiter: directed vector table, hand sequences for stall/withdraw/reset,
// and a randomized phase checked against a real-arithmetic reference model.
module tb_fp16_add_arbiter;
    import fp16_pkg::*;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [16*N-1:0] req_a, req_b;
    logic [N-1:0]   req_ready;
    logic           resp_valid, resp_ready;
    logic [15:0]    resp_sum;
    logic [1:0]     resp_id;
    logic [16*N-1:0] stat_cnt;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic        m_valid;
    int          m_id;
    logic [15:0] m_sum;
    int          m_last;
    int          m_cnt [N];
    int          last_gnt;
    logic [N-1:0] seen_rdy;
    logic [15:0] ra [N];
    logic [15:0] rb [N];

    typedef struct {
        int          req;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] sum;
    } vec_t;
    vec_t vecs [8];

    int order [5] = '{0, 1, 2, 3, 0};

    fp16_add_arbiter #(.N_REQ(N), .ID_W(2)) dut (
        .CLK        (clk),
        .RESET      (rst),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_sum   (resp_sum),
        .resp_id    (resp_id),
        .stat_cnt   (stat_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic real pow2(input int k);
        real r = 1.0;
        if (k >= 0) repeat (k) r = r * 2.0;
        else        repeat (-k) r = r / 2.0;
        return r;
    endfunction

    function automatic real f2r(input logic [15:0] h);
        real v;
        if (h[14:10] == 5'd0) return 0.0;
        v = (1.0 + real'(h[9:0]) / 1024.0) * pow2(int'(h[14:10]) - 15);
        return h[15] ? -v : v;
    endfunction

    // Round toward zero, flush results below the normal range
    function automatic logic [15:0] r2f(input real v);
        logic s;
        real  m;
        int   e, man;
        if (v == 0.0) return 16'h0000;
        s = (v < 0.0);
        m = s ? -v : v;
        e = 15;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0)  begin m = m * 2.0; e--; end
        if (e <= 0) return 16'h0000;
        man = $rtoi((m - 1.0) * 1024.0);
        return {s, 5'(e), 10'(man)};
    endfunction

    function automatic logic [15:0] ref_add(input logic [15:0] a, input logic [15:0] b);
        return r2f(f2r(a) + f2r(b));
    endfunction

    function automatic logic [15:0] rand_fp();
        return {1'($urandom), 5'($urandom_range(25, 5)), 10'($urandom)};
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_id    = 0;
        m_sum   = 16'h0000;
        m_last  = N - 1;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
    endtask

    task automatic drive_ops();
        for (int i = 0; i < N; i++) begin
            req_a[16*i +: 16] = ra[i];
            req_b[16*i +: 16] = rb[i];
        end
    endtask

    // One clock: check outputs at the negedge against the model, advance the model at the posedge
    task automatic step();
        int w, i;
        logic [N-1:0] exp_rdy;
        logic [16*N-1:0] exp_stat;
        @(negedge clk);
        w = -1;
        if (!m_valid || resp_ready) begin
            for (int k = 1; k <= N; k++) begin
                i = (m_last + k) % N;
                if (w < 0 && req_valid[i]) w = i;
            end
        end
        exp_rdy = '0;
        if (w >= 0) exp_rdy[w] = 1'b1;
        seen_rdy = req_ready;
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        chk("resp_valid", 64'(resp_valid), 64'(m_valid));
        if (m_valid) begin
            chk("resp_id", 64'(resp_id), 64'(m_id));
            chk("resp_sum", 64'(resp_sum), 64'(m_sum));
        end
        exp_stat = '0;
`ifdef FPADD_ARB_STATS_EN
        for (int j = 0; j < N; j++) exp_stat[16*j +: 16] = 16'(m_cnt[j]);
`endif
        chk("stat_cnt", 64'(stat_cnt), 64'(exp_stat));
        @(posedge clk);
        if (rst) begin
            model_reset();
            w = -1;
        end else if (w >= 0) begin
            m_valid = 1'b1;
            m_id    = w;
            m_sum   = ref_add(req_a[16*w +: 16], req_b[16*w +: 16]);
            m_last  = w;
            if (m_cnt[w] < 65535) m_cnt[w]++;
        end else if (resp_ready) begin
            m_valid = 1'b0;
        end
        last_gnt = w;
        #1;
    endtask

    initial begin
        int n6;
        vecs[0] = '{0, 16'h3C00, 16'h4000, 16'h4200};
        vecs[1] = '{1, 16'h3E00, 16'h3E00, 16'h4200};
        vecs[2] = '{2, 16'h4200, 16'hBC00, 16'h4000};
        vecs[3] = '{3, 16'h3C00, 16'h0000, 16'h3C00};
        vecs[4] = '{0, 16'h4000, 16'hC000, 16'h0000};
        vecs[5] = '{1, 16'h4900, 16'hC500, 16'h4500};
        vecs[6] = '{2, 16'h3C00, 16'h1000, 16'h3C00};
        vecs[7] = '{3, 16'h3C00, 16'h9000, 16'h3BFF};

        rst = 1'b1; req_valid = '0; resp_ready = 1'b0;
        for (int i = 0; i < N; i++) begin ra[i] = '0; rb[i] = '0; end
        drive_ops();
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        chk("rst_valid", 64'(resp_valid), 64'd0);
        chk("rst_id", 64'(resp_id), 64'd0);
        chk("rst_sum", 64'(resp_sum), 64'd0);
        chk("rst_stat", 64'(stat_cnt), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd0);
        rst = 1'b0;

        // single request
        resp_ready = 1'b1;
        ra[0] = FP16_ONE; rb[0] = FP16_TWO; drive_ops();
        req_valid = 4'b0001;
        step();
        chk("t1_ready", 64'(seen_rdy), 64'b0001);
        req_valid = '0;
        chk("t1_valid", 64'(resp_valid), 64'd1);
        chk("t1_id", 64'(resp_id), 64'd0);
        chk("t1_sum", 64'(resp_sum), 64'(FP16_THREE));

        // arithmetic vector table, back-to-back
        foreach (vecs[v]) begin
            ra[vecs[v].req] = vecs[v].a; rb[vecs[v].req] = vecs[v].b; drive_ops();
            req_valid = '0;
            req_valid[vecs[v].req] = 1'b1;
            step();
            chk("vec_ready", 64'(seen_rdy), 64'(1) << vecs[v].req);
            req_valid = '0;
            chk("vec_id", 64'(resp_id), 64'(vecs[v].req));
            chk("vec_sum", 64'(resp_sum), 64'(vecs[v].sum));
        end
        step();
        chk("vec_drain", 64'(resp_valid), 64'd0);

        // fairness from reset
        rst = 1'b1; step(); rst = 1'b0;
        for (int i = 0; i < N; i++) begin ra[i] = 16'h3E00; rb[i] = 16'h3E00; end
        drive_ops();
        req_valid = 4'b1111;
        foreach (order[j]) begin
            step();
            chk("t2_grant", 64'(seen_rdy), 64'(1) << order[j]);
            chk("t2_id", 64'(resp_id), 64'(order[j]));
            chk("t2_sum", 64'(resp_sum), 64'h4200);
        end

        // stall with req1 pending; req2 appears then withdraws before any grant
        resp_ready = 1'b0;
        ra[1] = 16'h4000; rb[1] = 16'h4000; drive_ops();
        for (int j = 0; j < 5; j++) begin
            req_valid = (j == 1 || j == 2) ? 4'b0110 : 4'b0010;
            step();
            chk("t3_stall_ready", 64'(seen_rdy), 64'd0);
            chk("t3_hold_id", 64'(resp_id), 64'd0);
            chk("t3_hold_sum", 64'(resp_sum), 64'h4200);
        end
        req_valid = 4'b0010;
        resp_ready = 1'b1;
        step();
        chk("t3_refill_ready", 64'(seen_rdy), 64'b0010);
        chk("t3_refill_id", 64'(resp_id), 64'd1);
        chk("t3_refill_sum", 64'(resp_sum), 64'h4400);
        req_valid = '0;
        step();
        chk("t4_no_id2", 64'(resp_valid), 64'd0);

        // reset with slot full and req3 pending
        resp_ready = 1'b0;
        req_valid = 4'b0001;
        step();
        req_valid = 4'b1000;
        step();
        chk("t5_full", 64'(resp_valid), 64'd1);
        rst = 1'b1;
        step();
        chk("t5_valid", 64'(resp_valid), 64'd0);
        chk("t5_sum", 64'(resp_sum), 64'd0);
        chk("t5_stat", 64'(stat_cnt), 64'd0);
        rst = 1'b0;
        req_valid = 4'b1001;
        resp_ready = 1'b1;
        step();
        chk("t5_first", 64'(seen_rdy), 64'b0001);

        // randomized traffic: operands stable until granted, occasional withdraw
        req_valid = '0;
        for (int i = 0; i < N; i++) begin ra[i] = rand_fp(); rb[i] = rand_fp(); end
        drive_ops();
        for (int c = 0; c < 400; c++) begin
            resp_ready = ($urandom_range(3, 0) != 0);
            step();
            for (int i = 0; i < N; i++) begin
                if (last_gnt == i) begin
                    ra[i] = rand_fp(); rb[i] = rand_fp();
                    req_valid[i] = ($urandom_range(1, 0) == 1);
                end else if (req_valid[i]) begin
                    if ($urandom_range(15, 0) == 0) req_valid[i] = 1'b0;
                end else if ($urandom_range(2, 0) == 0) begin
                    ra[i] = rand_fp(); rb[i] = rand_fp();
                    req_valid[i] = 1'b1;
                end
            end
            drive_ops();
        end

        // grant counter saturation
        req_valid = '0;
        rst = 1'b1; step(); rst = 1'b0;
        resp_ready = 1'b1;
        req_valid = 4'b0010;
`ifdef FPADD_ARB_STATS_EN
        n6 = 70000;
`else
        n6 = 300;
`endif
        for (int c = 0; c < n6; c++) step();
        req_valid = '0;
`ifdef FPADD_ARB_STATS_EN
        chk("t6_sat", 64'(stat_cnt), 64'hFFFF_0000);
`else
        chk("t6_zero", 64'(stat_cnt), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
